// File: rtl/mips_instr_rom_loader_if.sv
// Streaming program-load port for the instruction ROM loader.
// The master (test harness / boot streamer) presents words; the slave (loader) accepts them.
interface mips_instr_rom_loader_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/mips_instr_rom_loader.sv
// Instruction-side memory responder: streams a program into a word store, then serves
// byte-swapped CPU fetches from the boot vector, detects halt and counts active run cycles.
module mips_instr_rom_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 64,
    parameter int          IDX_W       = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_instr_rom_loader_if.slave        load_bus,
    output logic                          loaded,
    output logic                          load_error,
    input  logic [31:0]                   instr_address,
    output logic [31:0]                   instr_readdata,
    input  logic                          cpu_active,
    output logic                          halted,
    output logic                          fetch_error,
    output logic [15:0]                   run_cycles
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH_WORDS);
    localparam logic [IDX_W:0] LAST_IDX  = (IDX_W + 1)'(DEPTH_WORDS - 1);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W + 1)'(1);
    localparam logic [31:0]    SPAN      = 32'(4 * DEPTH_WORDS);

    state_t           state;
    state_t           state_next;
    logic [IDX_W:0]   wcount;
    logic [31:0]      mem [DEPTH_WORDS];
    logic             handshake;
    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             aligned;
    logic             hit;
    logic [31:0]      word;

    assign load_bus.load_ready = (state == LOAD) && (wcount < DEPTH_CNT);
    assign handshake           = load_bus.load_valid && load_bus.load_ready;
    assign loaded              = (state != LOAD);

    assign off      = instr_address - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign in_range = (off < SPAN);
    assign aligned  = (off[1:0] == 2'b00);
    assign hit      = loaded && aligned && in_range && ({1'b0, idx} < wcount);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (handshake && (load_bus.load_last || (wcount == LAST_IDX))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((instr_address == 32'd0) && !cpu_active) begin
                    state_next = HALT;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = LOAD;
        endcase
    end

    // Store is deliberately not cleared on reset; wcount alone gates what is readable.
    always_ff @(posedge clk) begin
        if (!reset && handshake) begin
            mem[wcount[IDX_W-1:0]] <= load_bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcount      <= '0;
            load_error  <= 1'b0;
            fetch_error <= 1'b0;
            halted      <= 1'b0;
            run_cycles  <= 16'd0;
        end else begin
            if (handshake) begin
                wcount <= wcount + CNT_ONE;
                if ((wcount == LAST_IDX) && !load_bus.load_last) begin
                    load_error <= 1'b1;
                end
            end
            if (state == RUN) begin
                if (in_range && !aligned) begin
                    fetch_error <= 1'b1;
                end
                if (cpu_active && (run_cycles != 16'hFFFF)) begin
                    run_cycles <= run_cycles + 16'd1;
                end
                if ((instr_address == 32'd0) && !cpu_active) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    // Words are stored MSB-first and presented to the CPU with byte lanes reversed.
    always_comb begin
        word           = mem[idx];
        instr_readdata = 32'd0;
        if (hit) begin
            instr_readdata = {word[7:0], word[15:8], word[23:16], word[31:24]};
        end
    end

endmodule

// File: tb/tb_mips_instr_rom_loader.sv
// Randomized and directed self-checking bench for mips_instr_rom_loader against a
// behavioural model of the loader's rules.
module tb_mips_instr_rom_loader;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic [31:0] instr_address;
    logic        cpu_active;
    logic        loaded;
    logic        load_error;
    logic [31:0] instr_readdata;
    logic        halted;
    logic        fetch_error;
    logic [15:0] run_cycles;

    mips_instr_rom_loader_if load_bus ();

    mips_instr_rom_loader #(
        .BASE_ADDR   (32'hBFC00000),
        .DEPTH_WORDS (64),
        .IDX_W       (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_bus       (load_bus.slave),
        .loaded         (loaded),
        .load_error     (load_error),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .cpu_active     (cpu_active),
        .halted         (halted),
        .fetch_error    (fetch_error),
        .run_cycles     (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: a program image, how many words it holds, and phase flags.
    logic [31:0] model_mem [64];
    int          model_count;
    bit          model_loaded;
    bit          model_halted;
    bit          model_lerr;
    bit          model_ferr;
    int          model_rc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_fetch(input logic [31:0] addr);
        logic [31:0] o;
        logic [31:0] w;
        int          i;
        o = addr - BASE;
        if (!model_loaded || (o % 4) != 0 || o >= 256) return 32'd0;
        i = int'(o / 4);
        if (i >= model_count) return 32'd0;
        w = model_mem[i];
        return ((w & 32'hFF) << 24) | (((w >> 8) & 32'hFF) << 16)
             | (((w >> 16) & 32'hFF) << 8) | ((w >> 24) & 32'hFF);
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] d, input bit l,
                              input logic [31:0] addr, input bit act);
        logic [31:0] o;
        o = addr - BASE;
        if (!model_loaded) begin
            if (v && model_count < 64) begin
                model_mem[model_count] = d;
                model_count++;
                if (l) model_loaded = 1;
                else if (model_count == 64) begin
                    model_loaded = 1;
                    model_lerr   = 1;
                end
            end
        end else if (!model_halted) begin
            if (o < 256 && (o % 4) != 0) model_ferr = 1;
            if (act && model_rc < 65535) model_rc++;
            if (addr == 32'd0 && !act) model_halted = 1;
        end
    endtask

    task automatic check_regs(input string tag);
        checkOutput({tag, "_loaded"}, {31'd0, loaded}, {31'd0, model_loaded});
        checkOutput({tag, "_lerr"}, {31'd0, load_error}, {31'd0, model_lerr});
        checkOutput({tag, "_ferr"}, {31'd0, fetch_error}, {31'd0, model_ferr});
        checkOutput({tag, "_halted"}, {31'd0, halted}, {31'd0, model_halted});
        checkOutput({tag, "_rc"}, {16'd0, run_cycles}, 32'(model_rc));
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit l,
                                 input logic [31:0] addr, input bit act);
        bit exp_ready;
        load_bus.load_valid = v;
        load_bus.load_data  = d;
        load_bus.load_last  = l;
        instr_address       = addr;
        cpu_active          = act;
        #1;
        exp_ready = !model_loaded && model_count < 64;
        checkOutput("ready", {31'd0, load_bus.load_ready}, {31'd0, exp_ready});
        checkOutput("rdata", instr_readdata, model_fetch(addr));
        model_edge(v, d, l, addr, act);
        @(posedge clk);
        #1;
        check_regs("cyc");
        checkOutput("rdata_post", instr_readdata, model_fetch(addr));
    endtask

    task automatic do_reset();
        load_bus.load_valid = 1'b0;
        load_bus.load_data  = 32'd0;
        load_bus.load_last  = 1'b0;
        instr_address       = 32'd0;
        cpu_active          = 1'b0;
        reset               = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        model_count  = 0;
        model_loaded = 0;
        model_halted = 0;
        model_lerr   = 0;
        model_ferr   = 0;
        model_rc     = 0;
        check_regs("rst");
        checkOutput("rst_ready", {31'd0, load_bus.load_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] prog [3];
        logic [31:0] a;
        int          n;
        int          guard;
        bit          no_last;
        bit          v;
        prog[0] = 32'h24010020;
        prog[1] = 32'h00011823;
        prog[2] = 32'h04610003;
        reset = 1'b0;
        do_reset();

        // Load a three-word program and fetch it back byte-swapped.
        for (int i = 0; i < 3; i++) applyStimulus(1, prog[i], i == 2, BASE, 0);
        checkOutput("t1_loaded", {31'd0, loaded}, 32'd1);
        applyStimulus(0, 0, 0, BASE, 1);
        checkOutput("t1_w0", instr_readdata, 32'h20000124);
        applyStimulus(0, 0, 0, BASE + 4, 1);
        checkOutput("t1_w1", instr_readdata, 32'h23180100);
        applyStimulus(0, 0, 0, BASE + 8, 1);
        checkOutput("t1_w2", instr_readdata, 32'h03006104);
        applyStimulus(0, 0, 0, BASE + 12, 1);
        checkOutput("t2_unwritten", instr_readdata, 32'd0);
        applyStimulus(0, 0, 0, BASE + 32'h100, 1);
        checkOutput("t2_range", instr_readdata, 32'd0);
        applyStimulus(0, 0, 0, BASE + 2, 1);
        checkOutput("t2_misalign", instr_readdata, 32'd0);
        checkOutput("t2_ferr", {31'd0, fetch_error}, 32'd1);

        // Fill the whole store without a last marker, then check halt and run counting.
        do_reset();
        for (int i = 0; i < 64; i++) applyStimulus(1, $urandom, 0, BASE, 0);
        checkOutput("t3_ready", {31'd0, load_bus.load_ready}, 32'd0);
        checkOutput("t3_lerr", {31'd0, load_error}, 32'd1);
        applyStimulus(1, 32'hDEADBEEF, 1, BASE + 4 * 63, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, BASE + 4 * 32'(i), 1);
        applyStimulus(0, 0, 0, 32'd0, 0);
        checkOutput("t4_rc", {16'd0, run_cycles}, 32'd10);
        checkOutput("t4_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, BASE + 2, 1);
        checkOutput("t4_rc_frozen", {16'd0, run_cycles}, 32'd10);
        checkOutput("t4_ferr_halt", {31'd0, fetch_error}, 32'd0);

        // Mid-load reset hides old words; LOAD fetches return NOP and cannot halt.
        do_reset();
        applyStimulus(1, 32'h11111111, 0, BASE, 0);
        applyStimulus(1, 32'h22222222, 0, 32'd0, 0);
        checkOutput("t6_nohalt", {31'd0, halted}, 32'd0);
        do_reset();
        applyStimulus(1, 32'hAABBCCDD, 1, BASE, 0);
        applyStimulus(0, 0, 0, BASE + 4, 1);
        checkOutput("t5_old", instr_readdata, 32'd0);
        applyStimulus(0, 0, 0, BASE, 1);
        checkOutput("t5_new", instr_readdata, 32'hDDCCBBAA);

        // Randomized programs and fetch traffic against the model.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            n       = (t == 0) ? 64 : int'($urandom_range(1, 64));
            no_last = (n == 64) && ($urandom_range(0, 1) == 1);
            guard   = 0;
            while (!model_loaded && guard < 400) begin
                v = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 3) == 0) ? 32'd0 : BASE + 4 * $urandom_range(0, 63);
                applyStimulus(v, $urandom, v && !no_last && (model_count == n - 1), a,
                              $urandom_range(0, 1) == 1);
                guard++;
            end
            checkOutput("rnd_loaded", {31'd0, loaded}, 32'd1);
            for (int c = 0; c < 25; c++) begin
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: a = BASE + 4 * $urandom_range(0, 70);
                    4:          a = BASE + $urandom_range(0, 255);
                    5:          a = $urandom;
                    6:          a = 32'd0;
                    default:    a = BASE + 4 * 32'(n);
                endcase
                applyStimulus($urandom_range(0, 1) == 1, $urandom, 0, a,
                              $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_instr_rom_loader.md
Name: mips_instr_rom_loader

Overview:
Instruction-side responder for the Harvard CPU. It is the memory end of the instr_address/instr_readdata fetch interface. A streaming load port fills an internal word store, which then serves CPU fetches at the boot vector with the big-endian-to-lane byte swap applied. It also detects the CPU halt condition and counts active run cycles for test harnesses.

Parameters:
BASE_ADDR, 32'hBFC00000, byte address of word 0 (reset vector).
DEPTH_WORDS, 64, number of 32-bit words stored.
IDX_W, 6, index width; must equal clog2(DEPTH_WORDS).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  load word is presented.
load_ready  output  1  block accepts a load word.
load_data  input  32  instruction word in logical MSB-first order.
load_last  input  1  marks the final program word.
loaded  output  1  high in RUN and HALT states.
load_error  output  1  sticky: store filled without load_last.
instr_address  input  32  CPU fetch byte address.
instr_readdata  output  32  byte-swapped fetch data, combinational.
cpu_active  input  1  CPU active flag.
halted  output  1  sticky halt detected.
fetch_error  output  1  sticky: misaligned fetch seen in RUN.
run_cycles  output  16  count of RUN cycles with cpu_active=1, saturating.

Behaviour:
- States: LOAD, RUN, HALT. Reset enters LOAD.
- On reset: wcount=0, load_error=0, fetch_error=0, halted=0, run_cycles=0.
- Store contents are not cleared on reset. Words at index >= wcount always read as 0.
- load_ready = (state==LOAD) && (wcount<DEPTH_WORDS).
- LOAD transfer: a handshake occurs when load_valid && load_ready at a clock edge. It writes mem[wcount] <= load_data and increments wcount.
- Handshake with load_last=1: go to RUN next cycle.
- Handshake writing index DEPTH_WORDS-1 with load_last=0: go to RUN and set load_error=1.
- load_valid outside LOAD is ignored with no side effects.
- Fetch decode: off = instr_address - BASE_ADDR (32-bit wrap). idx = off[IDX_W+1:2].
- Fetch hit requires all of: state is RUN or HALT, off[1:0]==0, off < 4*DEPTH_WORDS, idx < wcount.
- On hit: instr_readdata = {w[7:0], w[15:8], w[23:16], w[31:24]}, where w = mem[idx]. Zero latency (async read).
- Any non-hit, including every fetch while in LOAD: instr_readdata = 0 (NOP).
- fetch_error: set at a clock edge in RUN when off < 4*DEPTH_WORDS and off[1:0] != 0. Sticky until reset.
- run_cycles: increments at each RUN-state edge with cpu_active=1. Saturates at 16'hFFFF. Frozen in HALT.
- Halt: at a RUN-state edge where instr_address==0 and cpu_active==0, go to HALT and set halted=1.
- Address 0 lies outside the store range, so instr_readdata=0 there.
- HALT is terminal until reset. Fetch reads remain served in HALT.
- Reset at any time, including mid-load: returns to LOAD with wcount=0. Previously loaded words become unreadable.
- Simultaneous load_last with the write to index DEPTH_WORDS-1: go to RUN with load_error=0.

Test Plan:
1. Reset, then load 0x24010020, 0x00011823, 0x04610003 (last on the 3rd) -> loaded=1 one cycle after the 3rd handshake. Fetch 0xBFC00000 -> 0x20000124. Fetch 0xBFC00004 -> 0x23180100. Fetch 0xBFC00008 -> 0x03006104.
2. After (1), fetch 0xBFC0000C (unwritten) -> 0. Fetch 0xBFC00100 (out of range) -> 0. Fetch 0xBFC00002 -> 0, and fetch_error=1 next cycle.
3. Stream 64 words with load_last=0 -> load_ready drops after the 64th handshake, load_error=1, state RUN. A 65th load_valid is ignored.
4. In RUN, hold cpu_active=1 for 10 cycles, then drive instr_address=0 with cpu_active=0 -> run_cycles=10, halted=1. Further cycles leave run_cycles=10.
5. Reset after 2 loaded words, reload 1 word with last -> fetch 0xBFC00004 returns 0. Word 0 reads the new value.
6. During LOAD, fetch 0xBFC00000 -> instr_readdata=0. Drive instr_address=0 with cpu_active=0 -> halted stays 0.
